// File: rtl/mem_port_sequencer.sv
// mem_port_sequencer
// Multi-cycle sequencer that shares one single-port memory between instruction
// fetch and data load/store. Each pass fetches the word at pc, lets the core
// decode it, performs the data access if one is needed, then pulses enable so
// the core commits exactly one instruction.
module mem_port_sequencer #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    input  logic [AW-1:0] pc,
    input  logic          d_rd,
    input  logic          d_wr,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] instr,
    output logic [DW-1:0] rdata,
    output logic          enable,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic [CW-1:0] instr_count,
    output logic [CW-1:0] stall_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECIDE = 3'd2,
        S_DATA   = 3'd3,
        S_EXEC   = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic          w_load_pc;     // capture pc as the next fetch address
    logic          w_load_data;   // capture the data access set-up in DECIDE
    logic          w_fetch_ack;
    logic          w_data_ack;
    logic          w_stalling;

    logic [DW-1:0] r_instr;
    logic [DW-1:0] r_rdata;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic [CW-1:0] r_instr_count;
    logic [CW-1:0] r_stall_count;

    // Acks only matter while a request is actually outstanding.
    assign w_fetch_ack = (r_state == S_FETCH) && mem_ack;
    assign w_data_ack  = (r_state == S_DATA) && mem_ack;
    assign w_stalling  = (r_state == S_FETCH) || (r_state == S_DECIDE) ||
                         (r_state == S_DATA);

    // State register; reset abandons any outstanding request.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode plus the load strobes for the address/control registers.
    always_comb begin
        w_state_next = r_state;
        w_load_pc    = 1'b0;
        w_load_data  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (run) begin
                    w_state_next = S_FETCH;
                    w_load_pc    = 1'b1;
                end
            end
            S_FETCH: begin
                if (mem_ack) begin
                    w_state_next = S_DECIDE;
                end
            end
            S_DECIDE: begin
                // A store takes priority if the decoder flags both.
                if (d_wr || d_rd) begin
                    w_state_next = S_DATA;
                    w_load_data  = 1'b1;
                end else begin
                    w_state_next = S_EXEC;
                end
            end
            S_DATA: begin
                if (mem_ack) begin
                    w_state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (run) begin
                    w_state_next = S_FETCH;
                    w_load_pc    = 1'b1;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Memory address/control registers; held constant while a request is open.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_load_pc) begin
            r_mem_we   <= 1'b0;
            r_mem_addr <= pc;
        end else if (w_load_data) begin
            r_mem_we   <= d_wr;
            r_mem_addr <= d_addr;
            if (d_wr) begin
                r_mem_wdata <= d_wdata;
            end
        end
    end

    // Instruction and load-data latches; each changes only on its own ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr <= '0;
            r_rdata <= '0;
        end else begin
            if (w_fetch_ack) begin
                r_instr <= mem_rdata;
            end
            if (w_data_ack && !r_mem_we) begin
                r_rdata <= mem_rdata;
            end
        end
    end

    // Free-running performance counters; both wrap silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr_count <= '0;
            r_stall_count <= '0;
        end else begin
            if (r_state == S_EXEC) begin
                r_instr_count <= r_instr_count + CW'(1);
            end
            if (w_stalling) begin
                r_stall_count <= r_stall_count + CW'(1);
            end
        end
    end

    assign enable      = (r_state == S_EXEC);
    assign mem_req     = (r_state == S_FETCH) || (r_state == S_DATA);
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign instr       = r_instr;
    assign rdata       = r_rdata;
    assign instr_count = r_instr_count;
    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_mem_port_sequencer.sv
// tb_mem_port_sequencer
// Table of instructions (kind, memory wait states, expected pass length) run
// back to back against a cycle-accurate memory responder; expected results go
// into a scoreboard queue when an instruction is issued and are popped when
// the sequencer pulses enable. Hand-written sequences cover reset, dropping
// run mid-instruction, and reset during an outstanding fetch.
module tb_mem_port_sequencer;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 5;   // small so the stall counter wraps during the run

    logic          clk;
    logic          reset;
    logic          run;
    logic [AW-1:0] pc;
    logic          d_rd;
    logic          d_wr;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] instr;
    logic [DW-1:0] rdata;
    logic          enable;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic [CW-1:0] instr_count;
    logic [CW-1:0] stall_count;

    mem_port_sequencer #(.AW(AW), .DW(DW), .CW(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .pc          (pc),
        .d_rd        (d_rd),
        .d_wr        (d_wr),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .instr       (instr),
        .rdata       (rdata),
        .enable      (enable),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .instr_count (instr_count),
        .stall_count (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind: 0 = ALU, 1 = load, 2 = store, 3 = load and store flagged together
    typedef struct {
        int          kind;
        int          fw;       // wait cycles before fetch ack
        int          dw;       // wait cycles before data ack
        logic [31:0] pc;
        logic [31:0] iw;       // instruction word returned by memory
        logic [31:0] addr;     // d_addr
        logic [31:0] wd;       // d_wdata
        logic [31:0] ld;       // word memory returns on the data ack
        bit          stray;    // drive mem_ack while no request is open
        bit          drop;     // drop run during DATA
        int          cycles;   // expected FETCH-entry..EXEC length, inclusive
    } vec_t;

    typedef struct {
        logic [31:0]   iw;
        logic [31:0]   rd;
        int            cycles;
        logic [CW-1:0] icount;
        logic [CW-1:0] scount;
    } exp_t;

    exp_t          sb_q[$];
    vec_t          vecs[8];
    vec_t          hv;
    int            n_total;
    int            n_pass;
    logic [31:0]   m_rdata;
    logic [CW-1:0] m_icount;
    logic [CW-1:0] m_scount;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Runs one instruction. Entry/exit: #1 after a rising edge.
    task automatic do_instr(input vec_t v, input logic [31:0] nxt_pc, input logic nxt_run);
        int   waited;
        int   cnt;
        bit   in_data;
        bit   got;
        bit   is_wr;
        exp_t e;
        exp_t popped;

        is_wr   = (v.kind == 2) || (v.kind == 3);
        d_rd    = (v.kind == 1) || (v.kind == 3);
        d_wr    = is_wr;
        d_addr  = v.addr;
        d_wdata = v.wd;

        if (v.kind == 1) m_rdata = v.ld;
        m_icount = m_icount + 1'b1;
        m_scount = m_scount + CW'(v.cycles - 1);
        e.iw     = v.iw;
        e.rd     = m_rdata;
        e.cycles = v.cycles;
        e.icount = m_icount;
        e.scount = m_scount;
        sb_q.push_back(e);

        waited  = 0;
        cnt     = 0;
        in_data = 0;
        got     = 0;
        popped  = '{default: 0};
        for (int b = 0; b < 100 && !got; b++) begin
            mem_ack   = 1'b0;
            mem_rdata = 32'hBAD0_0000 | 32'(b);
            if (mem_req) begin
                if (!in_data) begin
                    check("fetch_addr", mem_addr, v.pc);
                    check("fetch_we", {31'b0, mem_we}, 32'd0);
                    if (waited == v.fw) begin
                        mem_ack   = 1'b1;
                        mem_rdata = v.iw;
                        in_data   = 1;
                        waited    = 0;
                    end else begin
                        waited++;
                    end
                end else begin
                    if (v.drop) run = 1'b0;
                    check("data_addr", mem_addr, v.addr);
                    check("data_we", {31'b0, mem_we}, {31'b0, is_wr});
                    if (is_wr) check("data_wdata", mem_wdata, v.wd);
                    if (waited == v.dw) begin
                        mem_ack   = 1'b1;
                        mem_rdata = v.ld;
                    end else begin
                        waited++;
                    end
                end
            end else if (v.stray) begin
                mem_ack = 1'b1;
            end
            if (mem_req || cnt > 0) cnt++;
            if (enable) begin
                got = 1;
                check("sb_size", sb_q.size(), 32'd1);
                if (sb_q.size() > 0) popped = sb_q.pop_front();
                check("instr", instr, popped.iw);
                check("rdata", rdata, popped.rd);
                check("cycles", cnt, popped.cycles);
                pc  = nxt_pc;
                run = nxt_run;
            end
            tick();
        end
        check("enable_seen", {31'b0, got}, 32'd1);
        check("enable_single", {31'b0, enable}, 32'd0);
        check("instr_count", instr_count, popped.icount);
        check("stall_count", stall_count, popped.scount);
        $display("instr pc=%h kind=%0d cycles=%0d instr=%h rdata=%h icnt=%0d scnt=%0d",
                 v.pc, v.kind, cnt, instr, rdata, instr_count, stall_count);
    endtask

    initial begin
        n_total   = 0;
        n_pass    = 0;
        m_rdata   = 32'd0;
        m_icount  = '0;
        m_scount  = '0;
        reset     = 1'b1;
        run       = 1'b1;
        pc        = 32'h40;
        d_rd      = 1'b0;
        d_wr      = 1'b0;
        d_addr    = 32'd0;
        d_wdata   = 32'd0;
        mem_rdata = 32'd0;
        mem_ack   = 1'b0;

        //           kind fw dw pc        iw            addr          wd            ld            stray drop cycles
        vecs[0] = '{0, 0, 0, 32'h40, 32'h0085_1020, 32'hFFFF_FFF0, 32'h0,         32'h0,         0, 0, 3};
        vecs[1] = '{1, 3, 3, 32'h44, 32'h8C08_0100, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 0, 0, 10};
        vecs[2] = '{2, 0, 2, 32'h48, 32'hAC09_0200, 32'h0000_0200, 32'h1234_5678, 32'hFFFF_FFFF, 0, 0, 6};
        vecs[3] = '{3, 1, 0, 32'h4C, 32'hAC0A_0300, 32'h0000_0300, 32'hCAFE_F00D, 32'hEEEE_EEEE, 1, 0, 5};
        vecs[4] = '{1, 0, 0, 32'h50, 32'h8C0B_0104, 32'h0000_0104, 32'h0,         32'h0BAD_F00D, 1, 0, 4};
        vecs[5] = '{0, 2, 0, 32'h54, 32'h014B_6022, 32'hFFFF_FFF0, 32'h0,         32'h0,         1, 0, 5};
        vecs[6] = '{2, 0, 0, 32'h58, 32'hAC0C_0204, 32'h0000_0204, 32'hA5A5_0001, 32'h7777_7777, 0, 0, 4};
        vecs[7] = '{1, 1, 1, 32'h60, 32'h8C0D_0180, 32'h0000_0180, 32'h0,         32'h5A5A_5A5A, 0, 1, 6};

        // Reset held for two edges with run high.
        tick();
        check("rst_enable", {31'b0, enable}, 32'd0);
        check("rst_req", {31'b0, mem_req}, 32'd0);
        tick();
        check("rst_enable2", {31'b0, enable}, 32'd0);
        check("rst_req2", {31'b0, mem_req}, 32'd0);
        check("rst_we", {31'b0, mem_we}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_icount", instr_count, 32'd0);
        check("rst_scount", stall_count, 32'd0);
        reset = 1'b0;
        tick();
        check("first_req", {31'b0, mem_req}, 32'd1);
        check("first_addr", mem_addr, 32'h40);

        // Back-to-back instructions with run held high; the last one drops run.
        for (int i = 0; i < 8; i++) begin
            do_instr(vecs[i], (i < 7) ? vecs[i+1].pc : 32'hC0, (i < 7) ? 1'b1 : 1'b0);
        end

        // Parked in IDLE after the run drop.
        check("park_req", {31'b0, mem_req}, 32'd0);
        check("park_enable", {31'b0, enable}, 32'd0);
        tick();
        check("park_req2", {31'b0, mem_req}, 32'd0);
        check("park_enable2", {31'b0, enable}, 32'd0);

        // Restart at a new pc; stray ack in the IDLE cycle must be ignored.
        run = 1'b1;
        pc  = 32'hC0;
        hv  = '{0, 0, 0, 32'hC0, 32'h0000_0000, 32'hFFFF_FFF0, 32'h0, 32'h0, 1, 0, 3};
        do_instr(hv, 32'hD0, 1'b1);

        // Reset while a fetch is waiting on its ack.
        mem_ack = 1'b0;
        check("wait_req", {31'b0, mem_req}, 32'd1);
        check("wait_addr", mem_addr, 32'hD0);
        tick();
        reset = 1'b1;
        tick();
        check("rstf_req", {31'b0, mem_req}, 32'd0);
        check("rstf_enable", {31'b0, enable}, 32'd0);
        check("rstf_icount", instr_count, 32'd0);
        check("rstf_scount", stall_count, 32'd0);
        check("rstf_instr", instr, 32'd0);
        reset     = 1'b0;
        run       = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h1111_1111;
        tick();
        mem_ack = 1'b0;
        check("stray_instr", instr, 32'd0);
        check("stray_rdata", rdata, 32'd0);
        check("stray_req", {31'b0, mem_req}, 32'd0);
        check("stray_enable", {31'b0, enable}, 32'd0);
        check("sb_empty", sb_q.size(), 32'd0);
        $display("reset during fetch: req=%0d instr=%h icnt=%0d", mem_req, instr, instr_count);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
